lane_packer: RTL and testbench
==============================

# lane_packer

Parametrised, order-preserving lane compactor and beat packer for the edge-stream datapath. Sits between the sparse per-lane filter output and the write-back stream. Valid words of each input beat are squeezed to the low lanes in ascending lane order and accumulated across beats, so the output carries only full beats. A short partial beat is emitted only on stream end (`last`). Both sides use valid/ready handshakes with full backpressure.

## Interface
Parameters:
- LANES, 4: words per beat; power of two, 2..16.
- WIDTH, 64: bits per word.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  input beat present.
- in_ready  out  1  block accepts the input beat this cycle.
- in_mask  in  LANES  per-lane word valid; bit i qualifies lane i.
- in_data  in  LANES×WIDTH  lane words, lane 0 in the low slice.
- in_last  in  1  final beat of the stream.
- out_valid  out  1  output beat present.
- out_ready  in  1  downstream accepts the output beat.
- out_mask  out  LANES  valid lanes; always low-contiguous (2^k−1 form).
- out_data  out  LANES×WIDTH  packed words.
- out_last  out  1  final output beat of the stream.

## Operation
- Input handshake: a beat is accepted when in_valid && in_ready. Output handshake: a beat transfers when out_valid && out_ready.
- Stage C (compact):
  - Each accepted beat is compacted by prefix-sum of in_mask. Lane i with mask set goes to position popcount(in_mask[i-1:0]).
  - Result is registered with its count c (0..LANES) and last.
  - Mask-0 beats with last=0 are dropped at stage C and never reach the packer.
- Stage P (pack):
  - Holds residual r words (0..LANES−1) in lanes 0..r−1. Stage-C words are appended at positions r.., giving t = r + c.
  - State RUN consumes the stage-C beat when the output register is empty or transferring:
    - t ≥ LANES: emit lanes 0..LANES−1, mask all-ones; the remaining t−LANES words become the new residual.
    - t < LANES, last=0: no emit; residual = t.
    - t ≤ LANES, last=1: emit t words with out_last=1 and mask (1<<t)−1. This includes t=0, which emits mask 0 with out_last=1. Residual is then 0.
    - t > LANES, last=1: emit the full beat with out_last=0, keep t−LANES words, go to FLUSH.
  - FLUSH: stage-C consumption is blocked. When the output slot frees, emit the residual with out_last=1 and the matching mask, then set r=0 and go to RUN.
- Word order across the stream is strictly preserved; no word is duplicated or lost.
- Unused out_data lanes (mask 0) are driven to zero.

## Timing
- Latency is 2 cycles from input acceptance to out_valid, when that beat completes an output beat and out_ready was high.
- in_ready = !rst && (!c_valid || c_consumed): one-deep stage with combinational ready pass-through; no skid buffer.
- Sustained throughput is 1 beat/cycle when out_ready=1 and the input is dense. Each FLUSH costs 1 extra cycle.
- out_valid is held, and out_* are stable, until the transfer completes.
- Reset: out_valid=0, out_mask=0, out_data=0, out_last=0, in_ready=0 during rst. Stage C is emptied, r=0, state=RUN.
- Reset mid-stream or mid-FLUSH discards all buffered words; outputs are zero on the cycle after rst is sampled high.

## Configuration
- LANE_PACKER_STATS_EN defined:
  - Adds outputs stat_words_in and stat_beats_out, both 32 bits, wrapping.
  - stat_words_in counts accepted masked words; stat_beats_out counts output transfers.
  - Both clear on rst.
- LANE_PACKER_STATS_EN undefined: these ports and counters are absent; all other behaviour is identical.

## Structure
- Package lane_packer_pkg:
  - state enum pk_state_t {PK_RUN, PK_FLUSH}.
  - popcount function and prefix-position function, parametrised by lane count.
  - CNT_W = $clog2(LANES+1) helper.
- Sub-module lane_compact: combinational prefix-sum compaction (mask + data to packed data + count), instantiated once in stage C.

## Test plan
LANES=4; A..H denote distinct 64-bit words.
- Full beat: mask 1111 [A,B,C,D], last=0, out_ready=1 -> out [A,B,C,D], mask 1111, last=0, out_valid 2 cycles after accept.
- Cross-beat packing: mask 0101 [A,x,C,x], then mask 1010 [x,E,x,G] -> single out [A,C,E,G], mask 1111; nothing emitted after the first beat.
- Overflow at last: mask 0111 [A,B,C,x], then mask 0011 [D,E,x,x] last=1 -> out [A,B,C,D], mask 1111, last=0; next cycle out [E,0,0,0], mask 0001, last=1; then in_ready recovers.
- Empty terminator: mask 0000, last=1, residual 0 -> out mask 0000, out_last=1; mask 0000 with last=0 -> no output.
- Backpressure: out_ready=0 for 10 cycles under continuous full beats -> in_ready falls within 2 accepts; after release the output sequence is in order with no loss or duplicates.
- Reset mid-FLUSH: assert rst while in FLUSH -> next cycle out_valid=0, out_last=0, residual cleared; a following mask 0001 [H] last=1 -> out [H], mask 0001, last=1.

Source files
------------

// File: rtl/lane_packer_pkg.sv
// Shared types and helpers for the lane packer: FSM state, counter width and
// mask arithmetic used by both the compaction stage and the packing stage.
package lane_packer_pkg;

    localparam int MAX_LANES = 16;

    typedef enum logic [0:0] {
        PK_RUN   = 1'b0,
        PK_FLUSH = 1'b1
    } pk_state_t;

    // Bits needed to hold a word count in 0..lanes.
    function automatic int cnt_width(input int lanes);
        return $clog2(lanes + 1);
    endfunction

    function automatic int popcount(input logic [MAX_LANES-1:0] m, input int n);
        int c;
        c = 0;
        for (int i = 0; i < MAX_LANES; i++) begin
            if (i < n && m[i]) c++;
        end
        return c;
    endfunction

    // Destination slot of lane `lane` after squeezing out masked-off lanes.
    function automatic int prefix_pos(input logic [MAX_LANES-1:0] m, input int lane);
        return popcount(m, lane);
    endfunction

    function automatic logic [MAX_LANES-1:0] low_mask(input int n);
        logic [MAX_LANES-1:0] m;
        m = '0;
        for (int i = 0; i < MAX_LANES; i++) begin
            m[i] = (i < n);
        end
        return m;
    endfunction

endpackage

// File: rtl/lane_packer_if.sv
// Input and output beat streams of the lane packer. Both streams use
// valid/ready: a beat moves on a rising clk where valid && ready; valid must
// not depend on ready, and payload holds steady while valid waits for ready.
interface lane_packer_if #(
    parameter int LANES = 4,
    parameter int WIDTH = 64
);
    logic                     in_valid;
    logic                     in_ready;
    logic [LANES-1:0]         in_mask;
    logic [LANES*WIDTH-1:0]   in_data;
    logic                     in_last;

    logic                     out_valid;
    logic                     out_ready;
    logic [LANES-1:0]         out_mask;
    logic [LANES*WIDTH-1:0]   out_data;
    logic                     out_last;

    modport master (
        output in_valid, in_mask, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_mask, out_data, out_last
    );

    modport slave (
        input  in_valid, in_mask, in_data, in_last, out_ready,
        output in_ready, out_valid, out_mask, out_data, out_last
    );
endinterface

// File: rtl/lane_compact.sv
// Combinational prefix-sum compaction: masked words move to the low lanes in
// ascending lane order, unused lanes read zero, and the word count is reported.
module lane_compact
    import lane_packer_pkg::*;
#(
    parameter int LANES = 4,
    parameter int WIDTH = 64,
    parameter int CNT_W = cnt_width(LANES)
) (
    input  logic [LANES-1:0]       i_mask,
    input  logic [LANES*WIDTH-1:0] i_data,
    output logic [LANES*WIDTH-1:0] o_data,
    output logic [CNT_W-1:0]       o_count
);
    logic [MAX_LANES-1:0] w_mask_ext;

    assign w_mask_ext = MAX_LANES'(i_mask);

    always_comb begin
        o_data = '0;
        for (int i = 0; i < LANES; i++) begin
            if (i_mask[i]) begin
                o_data[prefix_pos(w_mask_ext, i)*WIDTH +: WIDTH] = i_data[i*WIDTH +: WIDTH];
            end
        end
    end

    assign o_count = CNT_W'(popcount(w_mask_ext, LANES));

endmodule

// File: rtl/lane_packer.sv
// Order-preserving lane compactor and beat packer: stage C compacts each input
// beat, stage P appends it to a residual and emits only full beats until last.
// Optional counters: define LANE_PACKER_STATS_EN.
module lane_packer
    import lane_packer_pkg::*;
#(
    parameter int LANES = 4,
    parameter int WIDTH = 64
) (
    input  logic            clk,
    input  logic            rst,
    lane_packer_if.slave    bus,
    output pk_state_t       o_state
`ifdef LANE_PACKER_STATS_EN
    ,
    output logic [31:0]     stat_words_in,
    output logic [31:0]     stat_beats_out
`endif
);
    localparam int CNT_W = cnt_width(LANES);
    localparam int LW    = LANES * WIDTH;
    localparam logic [CNT_W:0] LANES_T = (CNT_W+1)'(LANES);

    logic [LW-1:0]     w_cmp_data;
    logic [CNT_W-1:0]  w_cmp_cnt;

    logic              r_c_valid;
    logic [LW-1:0]     r_c_data;
    logic [CNT_W-1:0]  r_c_cnt;
    logic              r_c_last;

    pk_state_t         r_state;
    logic [LW-1:0]     r_res_data;
    logic [CNT_W-1:0]  r_res_cnt;

    logic              r_out_valid;
    logic [LW-1:0]     r_out_data;
    logic [LANES-1:0]  r_out_mask;
    logic              r_out_last;

    logic              w_out_free;
    logic              w_c_consume;
    logic              w_c_open;
    logic              w_accept;
    logic              w_keep;
    logic [CNT_W:0]    w_total;
    logic [2*LW-1:0]   w_comb;

    lane_compact #(
        .LANES (LANES),
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_compact (
        .i_mask  (bus.in_mask),
        .i_data  (bus.in_data),
        .o_data  (w_cmp_data),
        .o_count (w_cmp_cnt)
    );

    assign w_out_free  = !r_out_valid || bus.out_ready;
    assign w_c_consume = r_c_valid && (r_state == PK_RUN) && w_out_free;
    assign w_c_open    = !r_c_valid || w_c_consume;
    assign bus.in_ready = !rst && w_c_open;
    assign w_accept    = bus.in_valid && bus.in_ready;
    assign w_keep      = (w_cmp_cnt != '0) || bus.in_last;

    // Residual lanes above r and compacted lanes above c are always zero, so
    // OR-ing the shifted stage-C beat onto the residual yields the joined stream.
    assign w_total = {1'b0, r_res_cnt} + {1'b0, r_c_cnt};
    assign w_comb  = {{LW{1'b0}}, r_res_data}
                   | ({{LW{1'b0}}, r_c_data} << (int'(r_res_cnt) * WIDTH));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_c_valid   <= 1'b0;
            r_c_data    <= '0;
            r_c_cnt     <= '0;
            r_c_last    <= 1'b0;
            r_state     <= PK_RUN;
            r_res_data  <= '0;
            r_res_cnt   <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_mask  <= '0;
            r_out_last  <= 1'b0;
        end else begin
            if (w_c_open) begin
                r_c_valid <= w_accept && w_keep;
                if (w_accept) begin
                    r_c_data <= w_cmp_data;
                    r_c_cnt  <= w_cmp_cnt;
                    r_c_last <= bus.in_last;
                end
            end

            if (r_out_valid && bus.out_ready) r_out_valid <= 1'b0;

            case (r_state)
                PK_RUN: begin
                    if (w_c_consume) begin
                        if (w_total >= LANES_T) begin
                            r_out_valid <= 1'b1;
                            r_out_data  <= w_comb[LW-1:0];
                            r_out_mask  <= '1;
                            r_out_last  <= r_c_last && (w_total == LANES_T);
                            r_res_data  <= w_comb[2*LW-1:LW];
                            r_res_cnt   <= CNT_W'(w_total - LANES_T);
                            if (r_c_last && (w_total != LANES_T)) r_state <= PK_FLUSH;
                        end else if (r_c_last) begin
                            r_out_valid <= 1'b1;
                            r_out_data  <= w_comb[LW-1:0];
                            r_out_mask  <= LANES'(low_mask(int'(w_total)));
                            r_out_last  <= 1'b1;
                            r_res_data  <= '0;
                            r_res_cnt   <= '0;
                        end else begin
                            r_res_data  <= w_comb[LW-1:0];
                            r_res_cnt   <= CNT_W'(w_total);
                        end
                    end
                end
                PK_FLUSH: begin
                    if (w_out_free) begin
                        r_out_valid <= 1'b1;
                        r_out_data  <= r_res_data;
                        r_out_mask  <= LANES'(low_mask(int'(r_res_cnt)));
                        r_out_last  <= 1'b1;
                        r_res_data  <= '0;
                        r_res_cnt   <= '0;
                        r_state     <= PK_RUN;
                    end
                end
                default: r_state <= PK_RUN;
            endcase
        end
    end

    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign bus.out_mask  = r_out_mask;
    assign bus.out_last  = r_out_last;
    assign o_state       = r_state;

`ifdef LANE_PACKER_STATS_EN
    logic [31:0] r_words_in;
    logic [31:0] r_beats_out;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_words_in  <= '0;
            r_beats_out <= '0;
        end else begin
            if (w_accept) r_words_in <= r_words_in + 32'(popcount(MAX_LANES'(bus.in_mask), LANES));
            if (r_out_valid && bus.out_ready) r_beats_out <= r_beats_out + 32'd1;
        end
    end

    assign stat_words_in  = r_words_in;
    assign stat_beats_out = r_beats_out;
`endif

endmodule

// File: tb/tb_lane_packer.sv
// Bench for lane_packer (LANES=4, WIDTH=64): directed cases plus random beats
// scored against a word-queue model of the packing rules.
module tb_lane_packer;
    import lane_packer_pkg::*;

    localparam int LANES = 4;
    localparam int WIDTH = 64;
    localparam int LW    = LANES * WIDTH;
    localparam int EW    = 1 + LANES + LW;
    localparam int CW    = LW;

    logic      clk = 1'b0;
    logic      rst = 1'b1;
    pk_state_t dbg_state;
    logic      rand_rdy  = 1'b0;
    logic      fixed_rdy = 1'b1;

    int n_vec = 0;
    int n_err = 0;
    int n_acc = 0;
    int words_acc = 0;
    int beats_obs = 0;

    logic [EW-1:0]    exp_q[$];
    logic [WIDTH-1:0] pend_q[$];

    logic [EW-1:0]    mon_e;
    logic             prev_stall = 1'b0;
    logic [EW-1:0]    prev_out;

    logic [WIDTH-1:0] wa = 64'hA1A1_0000_0000_00A1;
    logic [WIDTH-1:0] wb = 64'hB2B2_0000_0000_00B2;
    logic [WIDTH-1:0] wc = 64'hC3C3_0000_0000_00C3;
    logic [WIDTH-1:0] wd = 64'hD4D4_0000_0000_00D4;
    logic [WIDTH-1:0] we = 64'hE5E5_0000_0000_00E5;
    logic [WIDTH-1:0] wg = 64'h6767_0000_0000_0067;
    logic [WIDTH-1:0] wh = 64'h8888_0000_0000_0088;
    logic [WIDTH-1:0] wx = 64'hDEAD_BEEF_DEAD_BEEF;

    lane_packer_if #(.LANES(LANES), .WIDTH(WIDTH)) bus ();

`ifdef LANE_PACKER_STATS_EN
    logic [31:0] stat_words_in;
    logic [31:0] stat_beats_out;
`endif

    lane_packer #(.LANES(LANES), .WIDTH(WIDTH)) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .o_state (dbg_state)
`ifdef LANE_PACKER_STATS_EN
        ,
        .stat_words_in  (stat_words_in),
        .stat_beats_out (stat_beats_out)
`endif
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        bus.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            bus.out_ready = rand_rdy ? ($urandom_range(0, 3) != 0) : fixed_rdy;
        end
    end

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [CW-1:0] got, input logic [CW-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic void model_emit(input int n, input logic l);
        logic [LW-1:0]    d;
        logic [LANES-1:0] m;
        d = '0;
        m = '0;
        for (int i = 0; i < n; i++) begin
            d[i*WIDTH +: WIDTH] = pend_q.pop_front();
            m[i] = 1'b1;
        end
        exp_q.push_back({l, m, d});
    endfunction

    function automatic void model_accept(input logic [LANES-1:0] m, input logic [LW-1:0] d, input logic l);
        if (m == '0 && !l) return;
        for (int i = 0; i < LANES; i++) begin
            if (m[i]) pend_q.push_back(d[i*WIDTH +: WIDTH]);
        end
        while (pend_q.size() > LANES || (pend_q.size() == LANES && !l)) model_emit(LANES, 1'b0);
        if (l) model_emit(pend_q.size(), 1'b1);
    endfunction

    function automatic void model_reset();
        exp_q.delete();
        pend_q.delete();
        words_acc = 0;
        beats_obs = 0;
    endfunction

    function automatic logic [LW-1:0] mk(input logic [WIDTH-1:0] w0, input logic [WIDTH-1:0] w1,
                                         input logic [WIDTH-1:0] w2, input logic [WIDTH-1:0] w3);
        return {w3, w2, w1, w0};
    endfunction

    function automatic logic [LW-1:0] rand_beat();
        logic [LW-1:0] d;
        for (int i = 0; i < LANES; i++) d[i*WIDTH +: WIDTH] = {$urandom(), $urandom()};
        return d;
    endfunction

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("hold_valid", CW'(bus.out_valid), CW'(1));
                check("hold_data", bus.out_data, prev_out[LW-1:0]);
            end
            if (bus.out_valid && bus.out_ready) begin
                beats_obs++;
                if (exp_q.size() == 0) begin
                    check("unexpected_beat", CW'(bus.out_mask), CW'(0));
                    n_err += (bus.out_mask == '0) ? 1 : 0;
                    if (bus.out_mask == '0) $display("FAIL unexpected_beat got=empty beat exp=none");
                end else begin
                    mon_e = exp_q.pop_front();
                    check("out_data", bus.out_data, mon_e[LW-1:0]);
                    check("out_mask", CW'(bus.out_mask), CW'(mon_e[LW +: LANES]));
                    check("out_last", CW'(bus.out_last), CW'(mon_e[EW-1]));
                end
            end
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_out   = {bus.out_last, bus.out_mask, bus.out_data};
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send(input logic [LANES-1:0] m, input logic [LW-1:0] d, input logic l);
        int t;
        t = 0;
        bus.in_valid = 1'b1;
        bus.in_mask  = m;
        bus.in_data  = d;
        bus.in_last  = l;
        @(negedge clk);
        while (!bus.in_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!bus.in_ready) begin
            check("in_ready_timeout", CW'(0), CW'(1));
        end else begin
            model_accept(m, d, l);
            n_acc++;
            words_acc += $countones(m);
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain();
        int t;
        t = 0;
        rand_rdy  = 1'b0;
        fixed_rdy = 1'b1;
        while (exp_q.size() != 0 && t < 500) begin
            cycles(1);
            t++;
        end
        cycles(3);
        check("drain_empty", CW'(exp_q.size()), CW'(0));
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int lat;
        int acc0;
        bus.in_valid = 1'b0;
        bus.in_mask  = '0;
        bus.in_data  = '0;
        bus.in_last  = 1'b0;
        rst = 1'b1;
        cycles(2);
        @(negedge clk);
        check("rst_in_ready", CW'(bus.in_ready), CW'(0));
        check("rst_out_valid", CW'(bus.out_valid), CW'(0));
        check("rst_out_mask", CW'(bus.out_mask), CW'(0));
        check("rst_out_data", bus.out_data, CW'(0));
        check("rst_out_last", CW'(bus.out_last), CW'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        cycles(1);

        // full beat and its latency
        send(4'b1111, mk(wa, wb, wc, wd), 1'b0);
        lat = 1;
        @(negedge clk);
        while (!bus.out_valid && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        check("latency", CW'(lat), CW'(2));
        drain();

        // cross-beat packing
        send(4'b0101, mk(wa, wx, wc, wx), 1'b0);
        send(4'b1010, mk(wx, we, wx, wg), 1'b0);
        drain();

        // overflow at last, then one flush beat
        send(4'b0111, mk(wa, wb, wc, wx), 1'b0);
        send(4'b0011, mk(wd, we, wx, wx), 1'b1);
        drain();
        check("ready_after_flush", CW'(bus.in_ready), CW'(1));

        // empty terminator, then mask-0 non-last beat that must vanish
        send(4'b0000, mk(wx, wx, wx, wx), 1'b1);
        send(4'b0000, mk(wx, wx, wx, wx), 1'b0);
        drain();

        // backpressure window under dense input
        fixed_rdy = 1'b0;
        acc0 = n_acc;
        fork
            begin
                for (int k = 0; k < 12; k++) send(4'b1111, rand_beat(), 1'b0);
            end
            begin
                repeat (10) @(negedge clk);
                check("bp_accepts_le2", CW'((n_acc - acc0) <= 2), CW'(1));
                check("bp_in_ready_low", CW'(bus.in_ready), CW'(0));
                @(posedge clk);
                #1;
                fixed_rdy = 1'b1;
            end
        join
        drain();

        // reset while stuck in FLUSH
        fixed_rdy = 1'b0;
        send(4'b0111, mk(wa, wb, wc, wx), 1'b0);
        send(4'b0011, mk(wd, we, wx, wx), 1'b1);
        cycles(3);
        @(negedge clk);
        check("in_flush", CW'(dbg_state), CW'(PK_FLUSH));
        @(posedge clk);
        #1;
        rst = 1'b1;
        model_reset();
        @(negedge clk);
        check("rst_flush_in_ready", CW'(bus.in_ready), CW'(0));
        @(posedge clk);
        #1;
        @(negedge clk);
        check("rst_flush_out_valid", CW'(bus.out_valid), CW'(0));
        check("rst_flush_out_last", CW'(bus.out_last), CW'(0));
        check("rst_flush_out_mask", CW'(bus.out_mask), CW'(0));
        check("rst_flush_state", CW'(dbg_state), CW'(PK_RUN));
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        fixed_rdy = 1'b1;
        cycles(1);
        send(4'b0001, mk(wh, wx, wx, wx), 1'b1);
        drain();

        // random stream with random backpressure and gaps
        rand_rdy = 1'b1;
        for (int k = 0; k < 300; k++) begin
            send(4'($urandom_range(0, 15)), rand_beat(), ($urandom_range(0, 7) == 0));
            if ($urandom_range(0, 3) == 0) cycles($urandom_range(1, 2));
        end
        send(4'b0000, rand_beat(), 1'b1);
        drain();

`ifdef LANE_PACKER_STATS_EN
        check("stat_words_in", CW'(stat_words_in), CW'(words_acc));
        check("stat_beats_out", CW'(stat_beats_out), CW'(beats_obs));
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        check("watchdog", CW'(0), CW'(1));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
